// File: rtl/ofmap_stream_reader.sv
// Drains the ofmap SRAM after write-back and serialises each MAC_COL-lane word onto a
// valid/ready element stream (pixel -> tile -> lane order), prefetching one word ahead.
module ofmap_stream_reader #(
    parameter int MAC_COL           = 16,
    parameter int OFMAP_BITWIDTH    = 32,
    parameter int OFMAP_ADDR_BIT    = 10,
    parameter int OFMAP_CHANNEL_NUM = 64,
    parameter int OFMAP_WIDTH       = 14,
    parameter int OFMAP_HEIGHT      = 14
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                start_in,
    output logic [OFMAP_ADDR_BIT-1:0]           ofmap_addr_out,
    output logic                                ofmap_read_en_out,
    input  logic [MAC_COL*OFMAP_BITWIDTH-1:0]   ofmap_data_in,
    output logic [OFMAP_BITWIDTH-1:0]           dout_data_out,
    output logic                                dout_valid_out,
    input  logic                                dout_ready_in,
    output logic                                dout_last_out,
    output logic                                busy_out,
    output logic                                done_out
);
    localparam int NUM_OUT_TILE = OFMAP_CHANNEL_NUM / MAC_COL;
    localparam int OFMAP_SIZE   = OFMAP_WIDTH * OFMAP_HEIGHT * NUM_OUT_TILE;
    localparam int CNT_W        = OFMAP_ADDR_BIT + 1;
    localparam int LANE_W       = $clog2(MAC_COL);
    localparam logic [CNT_W-1:0]  SIZE_C    = CNT_W'(OFMAP_SIZE);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(MAC_COL - 1);

    typedef logic [MAC_COL-1:0][OFMAP_BITWIDTH-1:0] word_t;
    typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_t;

    state_t                    state, state_next;
    word_t                     shift_reg, pf_reg, mem_word;
    logic                      pf_full, rd_pending;
    logic [LANE_W-1:0]         lane_cnt;
    logic [CNT_W-1:0]          issue_addr, load_cnt;
    logic [OFMAP_ADDR_BIT-1:0] last_addr;
    logic                      issue, lane_end, last_word;
    logic                      clear_cnt, shift_from_mem, shift_from_pf, pf_from_mem, lane_inc;

    assign mem_word  = ofmap_data_in;
    assign lane_end  = (lane_cnt == LAST_LANE);
    assign last_word = (load_cnt == SIZE_C);

    // Only one read may be outstanding, and only into an empty prefetch slot.
    assign issue = ((state == LOAD) || (state == STREAM)) && !pf_full && !rd_pending &&
                   (issue_addr < SIZE_C);

    assign ofmap_read_en_out = issue;
    assign ofmap_addr_out    = issue ? issue_addr[OFMAP_ADDR_BIT-1:0] : last_addr;
    assign dout_data_out     = dout_valid_out ? shift_reg[lane_cnt] : '0;
    assign dout_last_out     = dout_valid_out && lane_end && last_word;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        clear_cnt      = 1'b0;
        shift_from_mem = 1'b0;
        shift_from_pf  = 1'b0;
        pf_from_mem    = 1'b0;
        lane_inc       = 1'b0;
        dout_valid_out = 1'b0;
        busy_out       = 1'b0;
        done_out       = 1'b0;
        case (state)
            IDLE: begin
                if (start_in) begin
                    clear_cnt  = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                busy_out = 1'b1;
                if (pf_full) begin
                    shift_from_pf = 1'b1;
                    state_next    = STREAM;
                end else if (rd_pending) begin
                    shift_from_mem = 1'b1;
                    state_next     = STREAM;
                end
            end
            STREAM: begin
                busy_out       = 1'b1;
                dout_valid_out = 1'b1;
                pf_from_mem    = rd_pending;
                if (dout_ready_in) begin
                    if (!lane_end) begin
                        lane_inc = 1'b1;
                    end else if (last_word) begin
                        state_next = DONE;
                    end else if (pf_full) begin
                        shift_from_pf = 1'b1;
                    end else if (rd_pending) begin
                        // Word arriving exactly as the shift reg empties goes straight in.
                        shift_from_mem = 1'b1;
                        pf_from_mem    = 1'b0;
                    end else begin
                        state_next = LOAD;
                    end
                end
            end
            DONE: begin
                done_out   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            shift_reg  <= '0;
            pf_reg     <= '0;
            pf_full    <= 1'b0;
            rd_pending <= 1'b0;
            lane_cnt   <= '0;
            issue_addr <= '0;
            load_cnt   <= '0;
            last_addr  <= '0;
        end else begin
            rd_pending <= issue;
            if (issue) begin
                issue_addr <= issue_addr + CNT_W'(1);
                last_addr  <= issue_addr[OFMAP_ADDR_BIT-1:0];
            end
            if (clear_cnt) begin
                issue_addr <= '0;
                load_cnt   <= '0;
                lane_cnt   <= '0;
                pf_full    <= 1'b0;
            end
            if (shift_from_mem) begin
                shift_reg <= mem_word;
                load_cnt  <= load_cnt + CNT_W'(1);
                lane_cnt  <= '0;
            end else if (shift_from_pf) begin
                shift_reg <= pf_reg;
                pf_full   <= 1'b0;
                load_cnt  <= load_cnt + CNT_W'(1);
                lane_cnt  <= '0;
            end else if (lane_inc) begin
                lane_cnt <= lane_cnt + LANE_W'(1);
            end
            if (pf_from_mem) begin
                pf_reg  <= mem_word;
                pf_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ofmap_stream_reader.sv
// Self-checking bench for ofmap_stream_reader: cycle table for reset/latency, then full
// drains checked against an arithmetic model of the NHWC element order.
module tb_ofmap_stream_reader;
    localparam int MAC_COL  = 16;
    localparam int BW       = 32;
    localparam int ADDR_BIT = 10;
    localparam int CH       = 64;
    localparam int W        = 14;
    localparam int H        = 14;
    localparam int SIZE     = W * H * (CH / MAC_COL);
    localparam int TOTAL    = SIZE * MAC_COL;

    logic                    clk = 1'b0;
    logic                    rstn = 1'b0;
    logic                    start_in = 1'b0;
    logic                    dout_ready_in = 1'b0;
    logic [ADDR_BIT-1:0]     ofmap_addr_out;
    logic                    ofmap_read_en_out;
    logic [MAC_COL*BW-1:0]   ofmap_data_in;
    logic [BW-1:0]           dout_data_out;
    logic                    dout_valid_out;
    logic                    dout_last_out;
    logic                    busy_out;
    logic                    done_out;
    logic [ADDR_BIT-1:0]     sram_addr_q = '0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic                rstn;
        logic                start;
        logic                ready;
        logic                exp_valid;
        logic                exp_rd;
        logic [ADDR_BIT-1:0] exp_addr;
        logic                exp_busy;
        logic                exp_done;
        logic                exp_last;
        logic                chk_data;
        logic [BW-1:0]       exp_data;
    } vec_t;

    ofmap_stream_reader #(
        .MAC_COL(MAC_COL), .OFMAP_BITWIDTH(BW), .OFMAP_ADDR_BIT(ADDR_BIT),
        .OFMAP_CHANNEL_NUM(CH), .OFMAP_WIDTH(W), .OFMAP_HEIGHT(H)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .start_in(start_in),
        .ofmap_addr_out(ofmap_addr_out),
        .ofmap_read_en_out(ofmap_read_en_out),
        .ofmap_data_in(ofmap_data_in),
        .dout_data_out(dout_data_out),
        .dout_valid_out(dout_valid_out),
        .dout_ready_in(dout_ready_in),
        .dout_last_out(dout_last_out),
        .busy_out(busy_out),
        .done_out(done_out)
    );

    always #5 clk = ~clk;

    function automatic logic [MAC_COL*BW-1:0] makeWord(input logic [ADDR_BIT-1:0] a);
        logic [MAC_COL*BW-1:0] w;
        w = '0;
        for (int k = 0; k < MAC_COL; k++) begin
            w[k*BW +: BW] = {6'd0, a, 16'(k)};
        end
        return w;
    endfunction

    // One-cycle-latency SRAM holding the {addr, lane} pattern.
    always @(posedge clk) begin
        if (ofmap_read_en_out) sram_addr_q <= ofmap_addr_out;
    end
    assign ofmap_data_in = makeWord(sram_addr_q);

    function automatic logic [BW-1:0] expElem(input int e);
        int a;
        int k;
        a = e / MAC_COL;
        k = e % MAC_COL;
        return {16'(a), 16'(k)};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic rdy);
        @(negedge clk);
        rstn          = r;
        start_in      = s;
        dout_ready_in = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic runDrain(input bit random_ready, input int restart_beat, input int abort_beat);
        int e = 0;
        int reads = 0;
        int cyc = 0;
        int last_hs = -10;
        int bad_start = bad;
        bit finished = 1'b0;
        bit aborted = 1'b0;
        bit restarted = 1'b0;
        bit stalled = 1'b0;
        bit prev_rd = 1'b0;
        @(negedge clk);
        start_in      = 1'b1;
        dout_ready_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        while (!finished && !aborted && cyc < 40000 && (bad - bad_start) < 50) begin
            cyc++;
            if (abort_beat >= 0 && e >= abort_beat && prev_rd) begin
                // A read issued last cycle is still in flight at this reset edge.
                rstn = 1'b0;
                @(posedge clk);
                #1;
                checkOutput("abort_valid", 32'(dout_valid_out), 32'd0);
                checkOutput("abort_read_en", 32'(ofmap_read_en_out), 32'd0);
                checkOutput("abort_busy", 32'(busy_out), 32'd0);
                aborted = 1'b1;
                @(negedge clk);
                rstn = 1'b1;
            end else begin
                dout_ready_in = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                start_in = 1'b0;
                if (restart_beat >= 0 && !restarted && e >= restart_beat) begin
                    start_in  = 1'b1;
                    restarted = 1'b1;
                end
                #1;
                if (stalled) checkOutput("stall_hold_valid", 32'(dout_valid_out), 32'd1);
                if (!random_ready && e > 0 && e < TOTAL)
                    checkOutput("no_bubble", 32'(dout_valid_out), 32'd1);
                if (dout_valid_out) begin
                    if (e >= TOTAL) begin
                        checkOutput("extra_element", 32'(e), 32'(TOTAL - 1));
                    end else begin
                        checkOutput("elem_data", dout_data_out, expElem(e));
                        checkOutput("elem_last", 32'(dout_last_out), 32'(e == TOTAL - 1));
                    end
                    if (dout_ready_in) begin
                        last_hs = cyc;
                        e++;
                    end
                end
                stalled = dout_valid_out && !dout_ready_in;
                if (ofmap_read_en_out) begin
                    if (reads >= SIZE) checkOutput("extra_read", 32'(reads), 32'(SIZE - 1));
                    else checkOutput("read_addr", 32'(ofmap_addr_out), 32'(reads));
                    reads++;
                end
                prev_rd = ofmap_read_en_out;
                if (done_out) begin
                    checkOutput("done_after_last", 32'(cyc), 32'(last_hs + 1));
                    checkOutput("done_busy_low", 32'(busy_out), 32'd0);
                    checkOutput("done_elem_count", 32'(e), 32'(TOTAL));
                    finished = 1'b1;
                end else begin
                    checkOutput("busy_high", 32'(busy_out), 32'd1);
                end
                @(negedge clk);
            end
        end
        if (!aborted) begin
            checkOutput("drain_finished", 32'(finished), 32'd1);
            checkOutput("read_count", 32'(reads), 32'(SIZE));
            start_in = 1'b0;
            for (int i = 0; i < 5; i++) begin
                #1;
                checkOutput("tail_done", 32'(done_out), 32'd0);
                checkOutput("tail_valid", 32'(dout_valid_out), 32'd0);
                checkOutput("tail_read_en", 32'(ofmap_read_en_out), 32'd0);
                checkOutput("tail_busy", 32'(busy_out), 32'd0);
                @(negedge clk);
            end
        end
    endtask

    initial begin
        vec_t vecs[11];
        //          rstn  st   rdy  val  rd   addr   busy done last chkd data
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 10'd1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0000};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'd1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0001};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'd1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0002};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 10'd1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0003};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'd1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0004};

        $display("[TB] reset and latency table");
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].rstn, vecs[i].start, vecs[i].ready);
            checkOutput($sformatf("vec%0d_valid", i), 32'(dout_valid_out), 32'(vecs[i].exp_valid));
            checkOutput($sformatf("vec%0d_read_en", i), 32'(ofmap_read_en_out), 32'(vecs[i].exp_rd));
            checkOutput($sformatf("vec%0d_addr", i), 32'(ofmap_addr_out), 32'(vecs[i].exp_addr));
            checkOutput($sformatf("vec%0d_busy", i), 32'(busy_out), 32'(vecs[i].exp_busy));
            checkOutput($sformatf("vec%0d_done", i), 32'(done_out), 32'(vecs[i].exp_done));
            checkOutput($sformatf("vec%0d_last", i), 32'(dout_last_out), 32'(vecs[i].exp_last));
            if (vecs[i].chk_data)
                checkOutput($sformatf("vec%0d_data", i), dout_data_out, vecs[i].exp_data);
        end

        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;

        $display("[TB] full-rate drain");
        runDrain(1'b0, -1, -1);
        $display("[TB] random backpressure drain with start while busy");
        runDrain(1'b1, 100, -1);
        $display("[TB] reset mid-drain, then restart");
        runDrain(1'b0, -1, 5000);
        runDrain(1'b0, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
